// File: rtl/operand_bypass_unit.sv
// rtl/operand_bypass_unit.sv - Rs/Rt operand forwarding from the live ALU result and a short retire history
module operand_bypass_unit #(
    parameter int HIST_DEPTH = 2,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs_index,
    input  logic [4:0]        rt_index,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [4:0]        rd_index,
    input  logic [DATA_W-1:0] rd_value,
    input  logic              rd_write_en,
    output logic [DATA_W-1:0] bypassed_rs_val,
    output logic [DATA_W-1:0] bypassed_rt_val
);

    logic              hist_valid [HIST_DEPTH];
    logic [4:0]        hist_index [HIST_DEPTH];
    logic [DATA_W-1:0] hist_value [HIST_DEPTH];
    logic              hist_live  [HIST_DEPTH];

    // Entry 0 is the newest; writes to r0 are stored invalid so they can never match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_valid[i] <= 1'b0;
                hist_index[i] <= 5'd0;
                hist_value[i] <= '0;
            end
        end else begin
            hist_valid[0] <= rd_write_en && (rd_index != 5'd0);
            hist_index[0] <= rd_index;
            hist_value[0] <= rd_value;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hist_valid[i] <= hist_valid[i-1];
                hist_index[i] <= hist_index[i-1];
                hist_value[i] <= hist_value[i-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_live[i] = hist_valid[i] && !rst;
        end
    end

    // Scan oldest to newest so the youngest matching source is the last to assign.
    always_comb begin
        bypassed_rs_val = rs_val;
        bypassed_rt_val = rt_val;
        for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
            if (hist_live[i] && hist_index[i] == rs_index) bypassed_rs_val = hist_value[i];
            if (hist_live[i] && hist_index[i] == rt_index) bypassed_rt_val = hist_value[i];
        end
        if (rd_write_en && rd_index == rs_index) bypassed_rs_val = rd_value;
        if (rd_write_en && rd_index == rt_index) bypassed_rt_val = rd_value;
        if (rs_index == 5'd0) bypassed_rs_val = rs_val;
        if (rt_index == 5'd0) bypassed_rt_val = rt_val;
    end

endmodule

// File: tb/tb_operand_bypass_unit.sv
// tb/tb_operand_bypass_unit.sv - directed table-driven bench for operand_bypass_unit
module tb_operand_bypass_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_index, rt_index, rd_index;
    logic [31:0] rs_val, rt_val, rd_value;
    logic        rd_write_en;
    logic [31:0] bypassed_rs_val, bypassed_rt_val;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    operand_bypass_unit #(.HIST_DEPTH(2), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .rs_index(rs_index), .rt_index(rt_index),
        .rs_val(rs_val), .rt_val(rt_val),
        .rd_index(rd_index), .rd_value(rd_value), .rd_write_en(rd_write_en),
        .bypassed_rs_val(bypassed_rs_val), .bypassed_rt_val(bypassed_rt_val)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] rdv;
        logic [4:0]  rs;
        logic [31:0] rsv;
        logic [4:0]  rt;
        logic [31:0] rtv;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] rdv,
                         input logic [4:0] rs, input logic [31:0] rsv,
                         input logic [4:0] rt, input logic [31:0] rtv);
        rd_write_en = we; rd_index = rd; rd_value = rdv;
        rs_index = rs; rs_val = rsv; rt_index = rt; rt_val = rtv;
    endtask

    initial begin
        // One vector per cycle: applied after a falling edge, checked 1ns later, loaded at the next rising edge.
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd3,  32'h11, 5'd4,  32'h22, 32'h11,       32'h22};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  32'h0,  5'd6,  32'h66, 32'hDEADBEEF, 32'h66};
        vecs[2]  = '{1'b1, 5'd7,  32'hA,        5'd5,  32'h0,  5'd7,  32'h3,  32'hDEADBEEF, 32'hA};
        vecs[3]  = '{1'b1, 5'd7,  32'hB,        5'd7,  32'h0,  5'd5,  32'h9,  32'hB,        32'hDEADBEEF};
        vecs[4]  = '{1'b0, 5'd7,  32'hFF,       5'd7,  32'h0,  5'd5,  32'h9,  32'hB,        32'h9};
        vecs[5]  = '{1'b0, 5'd7,  32'hFF,       5'd7,  32'h0,  5'd8,  32'h44, 32'hB,        32'h44};
        vecs[6]  = '{1'b0, 5'd7,  32'hFF,       5'd7,  32'h31, 5'd8,  32'h44, 32'h31,       32'h44};
        vecs[7]  = '{1'b1, 5'd0,  32'h55,       5'd0,  32'h0,  5'd0,  32'h7,  32'h0,        32'h7};
        vecs[8]  = '{1'b0, 5'd9,  32'h99,       5'd0,  32'h2,  5'd9,  32'h21, 32'h2,        32'h21};
        vecs[9]  = '{1'b1, 5'd12, 32'h1234,     5'd12, 32'h1,  5'd12, 32'h2,  32'h1234,     32'h1234};
        vecs[10] = '{1'b1, 5'd12, 32'h5678,     5'd12, 32'h1,  5'd12, 32'h2,  32'h5678,     32'h5678};
        vecs[11] = '{1'b0, 5'd12, 32'h0,        5'd12, 32'h1,  5'd12, 32'h2,  32'h5678,     32'h5678};
        vecs[12] = '{1'b0, 5'd12, 32'h0,        5'd12, 32'h1,  5'd12, 32'h2,  32'h5678,     32'h5678};
        vecs[13] = '{1'b0, 5'd12, 32'h0,        5'd12, 32'h1,  5'd12, 32'h2,  32'h1,        32'h2};

        rst = 1'b1;
        drive(1'b0, 5'd3, 32'hEE, 5'd3, 32'h11, 5'd4, 32'h22);
        repeat (2) @(posedge clk);
        #1;
        check("reset_rs", bypassed_rs_val, 32'h11);
        check("reset_rt", bypassed_rt_val, 32'h22);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].we, vecs[i].rd, vecs[i].rdv, vecs[i].rs, vecs[i].rsv, vecs[i].rt, vecs[i].rtv);
            #1;
            check($sformatf("vec%0d_rs", i), bypassed_rs_val, vecs[i].exp_rs);
            check($sformatf("vec%0d_rt", i), bypassed_rt_val, vecs[i].exp_rt);
            @(negedge clk);
        end

        // Async reset between edges clears history at once; live forwarding still works during reset.
        drive(1'b1, 5'd8, 32'h77, 5'd8, 32'h1, 5'd0, 32'h0);
        @(negedge clk);
        drive(1'b0, 5'd8, 32'h0, 5'd8, 32'h1, 5'd0, 32'h0);
        #1;
        check("hist_r8_before_rst", bypassed_rs_val, 32'h77);
        #1 rst = 1'b1;
        #1;
        check("async_rst_rs", bypassed_rs_val, 32'h1);
        drive(1'b1, 5'd8, 32'h88, 5'd8, 32'h1, 5'd0, 32'h0);
        #1;
        check("live_during_rst", bypassed_rs_val, 32'h88);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd8, 32'h0, 5'd8, 32'h1, 5'd0, 32'h0);
        #1;
        check("no_shift_during_rst", bypassed_rs_val, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
